ofdm_frame_packer: RTL and testbench
====================================

# ofdm_frame_packer

- Upstream stage of the CWGAN-GP engine. Takes a complex baseband stream with one I/Q pair per beat and converts each sample to Q8.8.
- Buffers one frame of FRAME_LEN samples in a ping-pong bank. Re-emits the frame channel-major (all I, then all Q) on a single-word valid/ready stream, which is the order the generator/discriminator top expects on its degraded/clean inputs.
- Issues a one-cycle frame_start pulse ahead of each frame. One instance feeds the degraded path; a second feeds the clean path in training.

## Interface
Parameters:
- IN_WIDTH, 12, input sample width (signed)
- IN_FRAC, 11, input fractional bits; legal range 8 ≤ IN_FRAC and IN_WIDTH−(IN_FRAC−8) ≤ DATA_WIDTH
- DATA_WIDTH, 16, output width, Q8.8
- FRAME_LEN, 16, complex samples per frame (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- iq_i_in  in  IN_WIDTH  signed I sample
- iq_q_in  in  IN_WIDTH  signed Q sample
- iq_valid  in  1  input beat valid
- iq_sof  in  1  beat is first sample of a frame
- iq_ready  out  1  input can accept
- pk_out  out  DATA_WIDTH  signed Q8.8 output word
- pk_valid  out  1  output word valid
- pk_ready  in  1  downstream accepts
- pk_ch  out  1  0 = I word, 1 = Q word
- pk_last  out  1  final word of frame (Q, position FRAME_LEN−1)
- frame_start  out  1  one-cycle pulse, frame about to stream
- frame_drop  out  1  one-cycle pulse, partial frame discarded

## Operation
- **Conversion:** out = sign-extend(in) >>> (IN_FRAC−8), i.e. arithmetic shift with floor. No saturation is needed under the legal parameter range.
  - With defaults: 0x7FF → 0x00FF; 0x800 → 0xFF00; 0xFFF → 0xFFFF.
- **Banks:** two banks, each holding 2×FRAME_LEN words. Per-bank `full` flag, `wr_bank` pointer, `rd_bank` pointer, and fill position `wr_pos`.
- **Fill:** a handshake is iq_valid && iq_ready.
  - Each handshake writes the converted I and Q to position wr_pos of wr_bank.
  - At wr_pos == FRAME_LEN−1: set full[wr_bank], toggle wr_bank, wr_pos ← 0.
- **iq_ready** = !full[wr_bank].
- **Re-sync:** a handshake with iq_sof = 1 while wr_pos ≠ 0 discards the partial frame.
  - That sample is written at position 0 of the same bank, and wr_pos ← 1.
  - frame_drop pulses in the next cycle.
  - iq_sof at wr_pos == 0 is normal. A beat without iq_sof at position 0 is accepted (free-running).
- **Drain FSM:**
  - D_IDLE: move to D_START if full[rd_bank] is set.
  - D_START: frame_start = 1 for exactly this cycle; reset rd_ch/rd_pos; move to D_STREAM.
  - D_STREAM: pk_valid = 1; pk_out = bank[rd_bank][rd_ch][rd_pos]. On each pk_ready, advance rd_pos, wrapping to 0 and setting rd_ch ← 1 after I position FRAME_LEN−1.
  - On the handshake with pk_last: clear full[rd_bank], toggle rd_bank, return to D_IDLE.
- **Simultaneous events:**
  - Fill completing into one bank while the drain clears the other: both take effect at the same edge.
  - A bank cleared by the drain can be written starting the next cycle (iq_ready rises the cycle after the pk_last handshake).

## Timing
- **Reset values:** iq_ready = 1, pk_valid = 0, pk_out = 0, pk_ch = 0, pk_last = 0, frame_start = 0, frame_drop = 0. All flags, pointers and counters are cleared.
- **Reset mid-operation:** all buffered data is abandoned; no output pulse is generated.
- **Latency:** let cycle N be the cycle of the last-sample input handshake when the drain is idle.
  - frame_start is high in cycle N+1.
  - pk_valid is first high in cycle N+2.
  - With pk_ready held high, the frame takes 2×FRAME_LEN cycles and pk_last is in cycle N+1+2×FRAME_LEN.
- **Output hold:** pk_out, pk_ch and pk_last are stable while pk_valid && !pk_ready. pk_valid is never withdrawn without a handshake.
- **Frame gap:** at least 2 idle cycles (D_IDLE, D_START) between frames on the output.
- **Throughput:** sustained input ≤ 1 beat per 2 cycles. Faster input is throttled via iq_ready once both banks are full.

## Structure
- **Shared header ofdm_gan_params.vh:** DATA_WIDTH, FRAME_LEN and IN_CH defaults; Q8.8 fractional-bit constant (8); drain state encodings.
- **Sub-module pingpong_frame_bank:** dual bank storage with write port (bank, ch, pos, data) and combinational read port. Full flags live in the parent.

## Test plan
- **Single frame:** 16 beats with I = k<<3, Q = −(k<<3), iq_sof on k = 0, pk_ready = 1.
  - frame_start in cycle N+1.
  - Outputs 0x0000..0x000F with pk_ch = 0, then 0x0000, 0xFFFF..0xFFF1 with pk_ch = 1.
  - pk_last on word 31.
- **Conversion extremes:** I = 0x7FF, Q = 0x800 → 0x00FF and 0xFF00. I = 0x001 → 0x0000. Q = 0xFFF → 0xFFFF.
- **Back-pressure:** pk_ready low throughout, 3 frames offered.
  - iq_ready drops after the 32nd beat.
  - After pk_ready rises and frame 1's pk_last handshakes, iq_ready rises the next cycle.
  - All frames emerge in order, uncorrupted.
- **Re-sync:** iq_sof asserted at wr_pos = 5.
  - frame_drop pulses once.
  - The frame emitted starts from the re-sync sample; the first 5 samples never appear.
- **Random stall:** random iq_valid/pk_ready at 50% for 20 frames → a scoreboard matches every word. pk_out is stable while pk_valid && !pk_ready.
- **Reset mid-stream:** rst_n low at word 10 of the output.
  - All outputs take their reset values immediately.
  - The next fresh frame streams correctly with no stale words.

Source files
------------

// File: rtl/ofdm_frame_packer_pkg.sv
// Shared constants and drain FSM encoding for the OFDM frame packer.
package ofdm_frame_packer_pkg;

    localparam int DATA_WIDTH_DEF = 16;  // Q8.8 output word
    localparam int FRAME_LEN_DEF  = 16;  // complex samples per frame
    localparam int IN_CH          = 2;   // I and Q channels
    localparam int Q_FRAC         = 8;   // fractional bits of Q8.8

    typedef enum logic [1:0] {
        D_IDLE   = 2'd0,
        D_START  = 2'd1,
        D_STREAM = 2'd2
    } drain_state_e;

endpackage

// File: rtl/ofdm_frame_packer_bank.sv
// Two-bank frame storage: one dual-lane (I and Q) write port, combinational read port.
module pingpong_frame_bank
    import ofdm_frame_packer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAME_LEN  = FRAME_LEN_DEF,
    parameter int POS_W      = $clog2(FRAME_LEN)
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic                  wr_bank_i,
    input  logic [POS_W-1:0]      wr_pos_i,
    input  logic [DATA_WIDTH-1:0] wr_i_data_i,
    input  logic [DATA_WIDTH-1:0] wr_q_data_i,
    input  logic                  rd_bank_i,
    input  logic                  rd_ch_i,
    input  logic [POS_W-1:0]      rd_pos_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [2][IN_CH][FRAME_LEN];

    // Both channels of one sample are written in the same cycle.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_bank_i][1'b0][wr_pos_i] <= wr_i_data_i;
            mem_q[wr_bank_i][1'b1][wr_pos_i] <= wr_q_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_bank_i][rd_ch_i][rd_pos_i];

endmodule

// File: rtl/ofdm_frame_packer.sv
// Converts I/Q samples to Q8.8, buffers frames in a ping-pong bank and
// re-emits each frame channel-major (all I, then all Q) on a valid/ready stream.
module ofdm_frame_packer
    import ofdm_frame_packer_pkg::*;
#(
    parameter int IN_WIDTH   = 12,
    parameter int IN_FRAC    = 11,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAME_LEN  = FRAME_LEN_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [IN_WIDTH-1:0]   iq_i_in,
    input  logic signed [IN_WIDTH-1:0]   iq_q_in,
    input  logic                         iq_valid,
    input  logic                         iq_sof,
    output logic                         iq_ready,
    output logic signed [DATA_WIDTH-1:0] pk_out,
    output logic                         pk_valid,
    input  logic                         pk_ready,
    output logic                         pk_ch,
    output logic                         pk_last,
    output logic                         frame_start,
    output logic                         frame_drop
);

    localparam int              SH       = IN_FRAC - Q_FRAC;
    localparam int              POS_W    = $clog2(FRAME_LEN);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(FRAME_LEN - 1);

    drain_state_e     state_q, state_d;
    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [POS_W-1:0] wr_pos_q, wr_pos_d;
    logic             rd_ch_q, rd_ch_d;
    logic [POS_W-1:0] rd_pos_q, rd_pos_d;
    logic             drop_q, drop_d;

    logic signed [IN_WIDTH-1:0] i_sh, q_sh;
    logic [DATA_WIDTH-1:0]      i_conv, q_conv, rd_data;
    logic                       in_hs, resync, fill_done, frame_done, streaming;
    logic [POS_W-1:0]           wr_addr;

    // Arithmetic shift floors; the signed size cast sign-extends to the output width.
    assign i_sh   = iq_i_in >>> SH;
    assign q_sh   = iq_q_in >>> SH;
    assign i_conv = DATA_WIDTH'(i_sh);
    assign q_conv = DATA_WIDTH'(q_sh);

    assign iq_ready   = !full_q[wr_bank_q];
    assign in_hs      = iq_valid && iq_ready;
    assign resync     = in_hs && iq_sof && (wr_pos_q != '0);
    assign fill_done  = in_hs && !resync && (wr_pos_q == LAST_POS);
    assign wr_addr    = resync ? '0 : wr_pos_q;
    assign streaming  = (state_q == D_STREAM);
    assign frame_done = pk_valid && pk_ready && pk_last;
    assign frame_drop = drop_q;

    pingpong_frame_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAME_LEN  (FRAME_LEN),
        .POS_W      (POS_W)
    ) u_bank (
        .clk_i       (clk),
        .wr_en_i     (in_hs),
        .wr_bank_i   (wr_bank_q),
        .wr_pos_i    (wr_addr),
        .wr_i_data_i (i_conv),
        .wr_q_data_i (q_conv),
        .rd_bank_i   (rd_bank_q),
        .rd_ch_i     (rd_ch_q),
        .rd_pos_i    (rd_pos_q),
        .rd_data_o   (rd_data)
    );

    // Fill side: position/bank advance, re-sync and full-flag bookkeeping.
    always_comb begin
        wr_pos_d  = wr_pos_q;
        wr_bank_d = wr_bank_q;
        full_d    = full_q;
        drop_d    = resync;
        if (in_hs) begin
            if (resync) begin
                wr_pos_d = POS_W'(1);
            end else if (wr_pos_q == LAST_POS) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_pos_d          = '0;
            end else begin
                wr_pos_d = wr_pos_q + 1'b1;
            end
        end
        // Fill and drain always target different banks, so both may update at once.
        if (frame_done) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    // Drain FSM next-state and stream outputs.
    always_comb begin
        state_d     = state_q;
        rd_bank_d   = rd_bank_q;
        rd_ch_d     = rd_ch_q;
        rd_pos_d    = rd_pos_q;
        pk_valid    = 1'b0;
        frame_start = 1'b0;
        pk_out      = '0;
        pk_ch       = 1'b0;
        pk_last     = 1'b0;
        case (state_q)
            D_IDLE: begin
                // Look ahead at a completing fill so frame_start follows the last beat directly.
                if (full_q[rd_bank_q] || (fill_done && (wr_bank_q == rd_bank_q))) begin
                    state_d = D_START;
                end
            end
            D_START: begin
                frame_start = 1'b1;
                rd_ch_d     = 1'b0;
                rd_pos_d    = '0;
                state_d     = D_STREAM;
            end
            D_STREAM: begin
                pk_valid = 1'b1;
                pk_out   = rd_data;
                pk_ch    = rd_ch_q;
                pk_last  = rd_ch_q && (rd_pos_q == LAST_POS);
                if (pk_ready) begin
                    if (rd_pos_q == LAST_POS) begin
                        rd_pos_d = '0;
                        if (rd_ch_q) begin
                            rd_ch_d   = 1'b0;
                            rd_bank_d = ~rd_bank_q;
                            state_d   = D_IDLE;
                        end else begin
                            rd_ch_d = 1'b1;
                        end
                    end else begin
                        rd_pos_d = rd_pos_q + 1'b1;
                    end
                end
            end
            default: state_d = D_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= D_IDLE;
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_pos_q  <= '0;
            rd_ch_q   <= 1'b0;
            rd_pos_q  <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_pos_q  <= wr_pos_d;
            rd_ch_q   <= rd_ch_d;
            rd_pos_q  <= rd_pos_d;
            drop_q    <= drop_d;
        end
    end

endmodule

// File: tb/tb_ofdm_frame_packer.sv
// Scoreboard bench for ofdm_frame_packer with default parameters.
module tb_ofdm_frame_packer;

    localparam int FL = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [11:0] iq_i_in, iq_q_in;
    logic               iq_valid, iq_sof, iq_ready;
    logic [15:0]        pk_out;
    logic               pk_valid, pk_ready, pk_ch, pk_last;
    logic               frame_start, frame_drop;

    int unsigned vec  = 0;
    int unsigned errs = 0;

    logic [17:0] sbq [$];          // {last, ch, data}
    logic [17:0] exp_w;
    logic [15:0] mi [FL];
    logic [15:0] mq [FL];
    int          mpos   = 0;
    int          drops  = 0;
    int          starts = 0;
    int          wcnt   = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_out;
    logic        prev_ch, prev_last;
    logic        rnd_on;

    always #5 clk = ~clk;

    ofdm_frame_packer #(
        .IN_WIDTH   (12),
        .IN_FRAC    (11),
        .DATA_WIDTH (16),
        .FRAME_LEN  (FL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .iq_i_in     (iq_i_in),
        .iq_q_in     (iq_q_in),
        .iq_valid    (iq_valid),
        .iq_sof      (iq_sof),
        .iq_ready    (iq_ready),
        .pk_out      (pk_out),
        .pk_valid    (pk_valid),
        .pk_ready    (pk_ready),
        .pk_ch       (pk_ch),
        .pk_last     (pk_last),
        .frame_start (frame_start),
        .frame_drop  (frame_drop)
    );

    // Q1.11 -> Q8.8: drop 3 fraction bits, replicate the sign into 7 upper bits.
    function automatic logic [15:0] cv(input logic [11:0] x);
        return {{7{x[11]}}, x[11:3]};
    endfunction

    // Monitor: input-side model feeds the scoreboard, output-side pops and compares.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            mpos       = 0;
            prev_stall = 1'b0;
            wcnt       = 0;
        end else begin
            if (prev_stall) begin
                vec++;
                if (pk_valid !== 1'b1 || pk_out !== prev_out || pk_ch !== prev_ch || pk_last !== prev_last) begin
                    errs++;
                    $display("FAIL hold: got v=%b out=%h ch=%b last=%b, need v=1 out=%h ch=%b last=%b",
                             pk_valid, pk_out, pk_ch, pk_last, prev_out, prev_ch, prev_last);
                end
            end
            prev_stall = pk_valid && !pk_ready;
            prev_out   = pk_out;
            prev_ch    = pk_ch;
            prev_last  = pk_last;
            if (frame_start) begin
                starts++;
                wcnt = 0;
            end
            if (frame_drop) drops++;
            if (pk_valid && pk_ready) begin
                vec++;
                if (sbq.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_word: got out=%h ch=%b last=%b, need no word", pk_out, pk_ch, pk_last);
                end else begin
                    exp_w = sbq.pop_front();
                    if ({pk_last, pk_ch, pk_out} !== exp_w) begin
                        errs++;
                        $display("FAIL word: got last=%b ch=%b out=%h, need last=%b ch=%b out=%h",
                                 pk_last, pk_ch, pk_out, exp_w[17], exp_w[16], exp_w[15:0]);
                    end
                end
                wcnt++;
            end
            if (iq_valid && iq_ready) begin
                if (iq_sof && mpos != 0) begin
                    mi[0] = cv(iq_i_in);
                    mq[0] = cv(iq_q_in);
                    mpos  = 1;
                end else begin
                    mi[mpos] = cv(iq_i_in);
                    mq[mpos] = cv(iq_q_in);
                    if (mpos == FL - 1) begin
                        for (int i = 0; i < FL; i++) sbq.push_back({1'b0, 1'b0, mi[i]});
                        for (int i = 0; i < FL; i++) sbq.push_back({(i == FL - 1), 1'b1, mq[i]});
                        mpos = 0;
                    end else begin
                        mpos++;
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [11:0] i, input logic [11:0] q, input logic sof);
        int   g = 0;
        logic acc;
        iq_i_in  = i;
        iq_q_in  = q;
        iq_sof   = sof;
        iq_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = iq_ready;
            @(posedge clk);
            #1;
            g++;
        end while (!acc && g < 5000);
        iq_valid = 1'b0;
        iq_sof   = 1'b0;
        if (!acc) begin
            vec++;
            errs++;
            $display("FAIL beat_timeout: got iq_ready=0 for %0d cycles, need acceptance", g);
        end
    endtask

    task automatic send_rand_frame(input bit gaps);
        for (int k = 0; k < FL; k++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(12'($urandom), 12'($urandom), (k == 0));
        end
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((sbq.size() != 0 || pk_valid) && g < 4000) begin
            @(posedge clk);
            #1;
            g++;
        end
        vec++;
        if (sbq.size() != 0 || pk_valid) begin
            errs++;
            $display("FAIL drain_timeout: got %0d words pending, need 0", sbq.size());
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        iq_valid = 1'b0;
        iq_sof   = 1'b0;
        iq_i_in  = '0;
        iq_q_in  = '0;
        pk_ready = 1'b1;
        rnd_on   = 1'b0;
        #2;
        vec++;
        if (iq_ready !== 1'b1 || pk_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_ready_valid: got iq_ready=%b pk_valid=%b, need 1 0", iq_ready, pk_valid);
        end
        vec++;
        if (pk_out !== 16'h0000 || pk_ch !== 1'b0 || pk_last !== 1'b0) begin
            errs++;
            $display("FAIL reset_data: got out=%h ch=%b last=%b, need 0000 0 0", pk_out, pk_ch, pk_last);
        end
        vec++;
        if (frame_start !== 1'b0 || frame_drop !== 1'b0) begin
            errs++;
            $display("FAIL reset_pulses: got start=%b drop=%b, need 0 0", frame_start, frame_drop);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_frame();
        logic [11:0] v;
        pk_ready = 1'b1;
        for (int k = 0; k < FL; k++) begin
            v = 12'(k * 8);
            send_beat(v, -v, (k == 0));
        end
        vec++;
        if (frame_start !== 1'b1) begin
            errs++;
            $display("FAIL single_start_N1: got %b, need 1", frame_start);
        end
        @(posedge clk);
        #1;
        vec++;
        if (pk_valid !== 1'b1 || frame_start !== 1'b0 || pk_out !== 16'h0000 || pk_ch !== 1'b0) begin
            errs++;
            $display("FAIL single_first_N2: got v=%b start=%b out=%h ch=%b, need 1 0 0000 0",
                     pk_valid, frame_start, pk_out, pk_ch);
        end
        repeat (31) @(posedge clk);
        #1;
        vec++;
        if (pk_last !== 1'b1 || pk_ch !== 1'b1 || pk_out !== 16'hFFF1) begin
            errs++;
            $display("FAIL single_last_N33: got last=%b ch=%b out=%h, need 1 1 fff1", pk_last, pk_ch, pk_out);
        end
        wait_drain();
    endtask

    task automatic test_conversion();
        pk_ready = 1'b1;
        send_beat(12'h7FF, 12'h800, 1'b1);
        send_beat(12'h001, 12'hFFF, 1'b0);
        for (int k = 2; k < FL; k++) send_beat(12'($urandom), 12'($urandom), 1'b0);
        @(posedge clk);
        #1;
        vec++;
        if (pk_out !== 16'h00FF) begin
            errs++;
            $display("FAIL conv_7ff: got %h, need 00ff", pk_out);
        end
        @(posedge clk);
        #1;
        vec++;
        if (pk_out !== 16'h0000) begin
            errs++;
            $display("FAIL conv_001: got %h, need 0000", pk_out);
        end
        repeat (15) @(posedge clk);
        #1;
        vec++;
        if (pk_out !== 16'hFF00 || pk_ch !== 1'b1) begin
            errs++;
            $display("FAIL conv_800: got out=%h ch=%b, need ff00 1", pk_out, pk_ch);
        end
        @(posedge clk);
        #1;
        vec++;
        if (pk_out !== 16'hFFFF) begin
            errs++;
            $display("FAIL conv_fff: got %h, need ffff", pk_out);
        end
        wait_drain();
    endtask

    task automatic test_back_pressure();
        pk_ready = 1'b0;
        send_rand_frame(1'b0);
        send_rand_frame(1'b0);
        @(negedge clk);
        vec++;
        if (iq_ready !== 1'b0) begin
            errs++;
            $display("FAIL bp_ready_drop: got iq_ready=%b, need 0", iq_ready);
        end
        @(posedge clk);
        #1;
        fork
            send_rand_frame(1'b0);
            begin
                int g = 0;
                repeat (10) @(posedge clk);
                #1;
                pk_ready = 1'b1;
                do begin
                    @(negedge clk);
                    g++;
                end while (!(pk_valid && pk_ready && pk_last) && g < 200);
                vec++;
                if (iq_ready !== 1'b0) begin
                    errs++;
                    $display("FAIL bp_ready_at_last: got iq_ready=%b after %0d cycles, need 0", iq_ready, g);
                end
                @(negedge clk);
                vec++;
                if (iq_ready !== 1'b1) begin
                    errs++;
                    $display("FAIL bp_ready_rise: got iq_ready=%b, need 1", iq_ready);
                end
            end
        join
        wait_drain();
    endtask

    task automatic test_resync();
        int d0;
        pk_ready = 1'b1;
        d0 = drops;
        for (int k = 0; k < 5; k++) send_beat(12'($urandom), 12'($urandom), (k == 0));
        send_beat(12'h3A8, 12'hC58, 1'b1);
        vec++;
        if (frame_drop !== 1'b1) begin
            errs++;
            $display("FAIL resync_drop_pulse: got %b, need 1", frame_drop);
        end
        @(posedge clk);
        #1;
        vec++;
        if (frame_drop !== 1'b0) begin
            errs++;
            $display("FAIL resync_drop_width: got %b, need 0", frame_drop);
        end
        for (int k = 1; k < FL; k++) send_beat(12'($urandom), 12'($urandom), 1'b0);
        wait_drain();
        vec++;
        if (drops - d0 != 1) begin
            errs++;
            $display("FAIL resync_drop_count: got %0d, need 1", drops - d0);
        end
    endtask

    task automatic test_random_stall();
        rnd_on = 1'b1;
        fork
            begin
                for (int f = 0; f < 20; f++) send_rand_frame(1'b1);
                wait_drain();
                rnd_on = 1'b0;
            end
            while (rnd_on) begin
                @(posedge clk);
                #1;
                pk_ready = ($urandom_range(0, 1) == 1);
            end
        join
        pk_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        int s0;
        int g = 0;
        pk_ready = 1'b1;
        s0 = starts;
        send_rand_frame(1'b0);
        do begin
            @(posedge clk);
            #2;
            g++;
        end while (!(starts > s0 && pk_valid && wcnt == 10) && g < 200);
        rst_n = 1'b0;
        #1;
        vec++;
        if ({iq_ready, pk_valid, pk_out, pk_ch, pk_last, frame_start, frame_drop} !== {1'b1, 1'b0, 16'h0, 4'b0}) begin
            errs++;
            $display("FAIL mid_reset_outputs: got rdy=%b v=%b out=%h ch=%b last=%b st=%b dr=%b, need 1 0 0000 0 0 0 0",
                     iq_ready, pk_valid, pk_out, pk_ch, pk_last, frame_start, frame_drop);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        s0 = starts;
        send_rand_frame(1'b0);
        wait_drain();
        vec++;
        if (starts - s0 != 1 || wcnt != 2 * FL) begin
            errs++;
            $display("FAIL mid_reset_fresh: got starts=%0d words=%0d, need 1 %0d", starts - s0, wcnt, 2 * FL);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_conversion();
        test_back_pressure();
        test_resync();
        test_random_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
